// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_cfg
// Description : Parametrised UART serializer with configurable data width,
//               parity and stop bits, a one-entry holding register with a
//               valid/ready handshake, RTS gating and back-to-back framing.
//               Timed by an external 1x baud tick.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_cfg #(
    parameter int DATA_BITS = 8,   // 5..9, sent LSB first
    parameter int PARITY    = 0,   // 0 none, 1 odd, 2 even
    parameter int STOP_BITS = 1    // 1 or 2
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 rts,
    output logic                 txd,
    output logic                 busy,
    output logic                 frame_done
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_SYNC   = 3'd1;
    localparam logic [2:0] c_START  = 3'd2;
    localparam logic [2:0] c_DATA   = 3'd3;
    localparam logic [2:0] c_PARITY = 3'd4;
    localparam logic [2:0] c_STOP   = 3'd5;

    localparam logic [3:0] c_LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic       c_LAST_STOP = 1'(STOP_BITS - 1);

    logic [2:0]           state_q,     state_d;
    logic [DATA_BITS-1:0] hold_q,      hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic                 par_q,       par_d;
    logic [3:0]           bit_cnt_q,   bit_cnt_d;
    logic                 stop_cnt_q,  stop_cnt_d;
    logic                 txd_q,       txd_d;
    logic                 frame_done_q, frame_done_d;

    logic w_write;
    logic w_load;

    // Holding register is writable only when empty and never during reset
    assign tx_ready   = ~hold_full_q & ~sys_rst;
    assign w_write    = tx_valid & tx_ready;
    assign busy       = (state_q != c_IDLE) | hold_full_q;
    assign txd        = txd_q;
    assign frame_done = frame_done_q;

    // State register: all sequential state, reset abandons any frame in flight
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= c_IDLE;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            bit_cnt_q    <= 4'd0;
            stop_cnt_q   <= 1'b0;
            txd_q        <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            txd_q        <= txd_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state logic: frame sequencing, holding register and shifter
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        par_d       = par_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        w_load      = 1'b0;

        case (state_q)
            c_IDLE: begin
                if (hold_full_q && rts) begin
                    w_load  = 1'b1;
                    state_d = c_SYNC;
                end
            end
            c_SYNC: begin
                if (baud_tick) state_d = c_START;
            end
            c_START: begin
                if (baud_tick) begin
                    state_d   = c_DATA;
                    bit_cnt_d = 4'd0;
                end
            end
            c_DATA: begin
                if (baud_tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == c_LAST_BIT) begin
                        state_d    = (PARITY != 0) ? c_PARITY : c_STOP;
                        stop_cnt_d = 1'b0;
                    end
                end
            end
            c_PARITY: begin
                if (baud_tick) begin
                    state_d    = c_STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            c_STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_q == c_LAST_STOP) begin
                        // Already bit-aligned, so a queued word skips SYNC
                        if (hold_full_q && rts) begin
                            w_load  = 1'b1;
                            state_d = c_START;
                        end else begin
                            state_d = c_IDLE;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = c_IDLE;
        endcase

        if (w_load) begin
            shift_d     = hold_q;
            par_d       = (PARITY == 1) ? ~(^hold_q) : (^hold_q);
            hold_full_d = 1'b0;
        end
        // A write landing with a load keeps the holding register full
        if (w_write) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    // Output logic: line level follows the state being entered this edge
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            c_START:  txd_d = 1'b0;
            c_DATA:   txd_d = shift_d[0];
            c_PARITY: txd_d = par_d;
            default:  txd_d = 1'b1;
        endcase
        frame_done_d = (state_q == c_STOP) && baud_tick && (stop_cnt_q == c_LAST_STOP);
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_cfg
// Description : Directed self-checking bench for uart_tx_cfg. Three instances
//               cover 8N1, 7E1 and 8O2 framings.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rts = 1'b1;

    logic [7:0] d0 = '0, d2 = '0;
    logic [6:0] d1 = '0;
    logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
    logic       rdy0, rdy1, rdy2;
    logic       txd0, txd1, txd2;
    logic       busy0, busy1, busy2;
    logic       fd0, fd1, fd2;

    int         sel = 0;
    logic       txd_s, busy_s, fd_s, rdy_s;

    int         checks = 0;
    int         errors = 0;

    always #5 sys_clk = ~sys_clk;

    uart_tx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .baud_tick(baud_tick),
        .tx_data(d0), .tx_valid(v0), .tx_ready(rdy0), .rts(rts),
        .txd(txd0), .busy(busy0), .frame_done(fd0));

    uart_tx_cfg #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_dut1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .baud_tick(baud_tick),
        .tx_data(d1), .tx_valid(v1), .tx_ready(rdy1), .rts(rts),
        .txd(txd1), .busy(busy1), .frame_done(fd1));

    uart_tx_cfg #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_dut2 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .baud_tick(baud_tick),
        .tx_data(d2), .tx_valid(v2), .tx_ready(rdy2), .rts(rts),
        .txd(txd2), .busy(busy2), .frame_done(fd2));

    // Route the instance under test to common observation signals
    always_comb begin
        txd_s  = txd0;  busy_s = busy0; fd_s = fd0; rdy_s = rdy0;
        if (sel == 1) begin
            txd_s = txd1; busy_s = busy1; fd_s = fd1; rdy_s = rdy1;
        end else if (sel == 2) begin
            txd_s = txd2; busy_s = busy2; fd_s = fd2; rdy_s = rdy2;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bit period: three quiet cycles then a tick; ends 1 time unit after the tick edge
    task automatic tick();
        repeat (3) @(posedge sys_clk);
        #1 baud_tick = 1'b1;
        @(posedge sys_clk);
        #1 baud_tick = 1'b0;
    endtask

    task automatic write_word(input logic [7:0] d);
        if (sel == 0) begin d0 = d; v0 = 1'b1; end
        else if (sel == 1) begin d1 = d[6:0]; v1 = 1'b1; end
        else begin d2 = d; v2 = 1'b1; end
        @(posedge sys_clk);
        #1 v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    endtask

    // Bits [first..n-1] of a frame, bit 0 = start, each seen after one tick
    task automatic expect_bits(input logic [15:0] bits, input int first, input int n, input string tag);
        for (int i = first; i < n; i++) begin
            tick();
            chk($sformatf("%s_txd%0d", tag, i), 16'(txd_s), 16'(bits[i]));
            chk($sformatf("%s_fd%0d", tag, i), 16'(fd_s), 16'd0);
        end
    endtask

    // Tick that closes the last stop bit: frame_done pulses for one cycle
    task automatic end_tick(input logic exp_txd, input string tag);
        tick();
        chk({tag, "_fd_hi"}, 16'(fd_s), 16'd1);
        chk({tag, "_txd_end"}, 16'(txd_s), 16'(exp_txd));
        @(posedge sys_clk);
        #1 chk({tag, "_fd_lo"}, 16'(fd_s), 16'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_txd", 16'(txd0), 16'd1);
        chk("rst_busy", 16'(busy0), 16'd0);
        chk("rst_fd", 16'(fd0), 16'd0);
        chk("rst_ready_low", 16'(rdy0), 16'd0);
        sys_rst = 1'b0;
        #1 chk("rst_ready_hi", 16'(rdy0), 16'd1);

        // 1: 8N1 0x55 -> 0,1,0,1,0,1,0,1,0,1
        sel = 0;
        write_word(8'h55);
        chk("t1_busy", 16'(busy_s), 16'd1);
        expect_bits({6'd0, 1'b1, 8'h55, 1'b0}, 0, 10, "t1");
        end_tick(1'b1, "t1");
        chk("t1_busy_end", 16'(busy_s), 16'd0);

        // 2: 7E1 0x23 -> start, 1,1,0,0,0,1,0, parity 1, stop
        sel = 1;
        write_word(8'h23);
        expect_bits({6'd0, 1'b1, 1'b1, 7'h23, 1'b0}, 0, 10, "t2");
        end_tick(1'b1, "t2");

        // 3: 8O2 0xFF -> start, eight 1s, parity 1, two stops
        sel = 2;
        write_word(8'hFF);
        expect_bits({4'd0, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0}, 0, 12, "t3");
        end_tick(1'b1, "t3");

        // 4: held by rts, then back-to-back frames
        sel = 0;
        rts = 1'b0;
        write_word(8'hA5);
        chk("t4_ready_low", 16'(rdy_s), 16'd0);
        chk("t4_busy", 16'(busy_s), 16'd1);
        for (int k = 0; k < 50; k++) begin
            tick();
            chk($sformatf("t4_hold%0d", k), 16'(txd_s), 16'd1);
        end
        rts = 1'b1;
        @(posedge sys_clk);
        #1 chk("t4_ready_after_load", 16'(rdy_s), 16'd1);
        write_word(8'h5A);
        expect_bits({6'd0, 1'b1, 8'hA5, 1'b0}, 0, 10, "t4a");
        end_tick(1'b0, "t4a");
        expect_bits({6'd0, 1'b1, 8'h5A, 1'b0}, 1, 10, "t4b");
        end_tick(1'b1, "t4b");

        // 5: rts dropped mid-frame, queued word waits
        write_word(8'h0F);
        expect_bits({6'd0, 1'b1, 8'h0F, 1'b0}, 0, 5, "t5a");
        rts = 1'b0;
        write_word(8'h81);
        expect_bits({6'd0, 1'b1, 8'h0F, 1'b0}, 5, 10, "t5a");
        end_tick(1'b1, "t5a");
        chk("t5_busy_held", 16'(busy_s), 16'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("t5_wait%0d", k), 16'(txd_s), 16'd1);
        end
        rts = 1'b1;
        @(posedge sys_clk);
        #1;
        expect_bits({6'd0, 1'b1, 8'h81, 1'b0}, 0, 10, "t5b");
        end_tick(1'b1, "t5b");

        // 6: reset during data bit 5 with a word queued, then a clean frame
        write_word(8'hF0);
        expect_bits({6'd0, 1'b1, 8'hF0, 1'b0}, 0, 3, "t6a");
        write_word(8'h99);
        expect_bits({6'd0, 1'b1, 8'hF0, 1'b0}, 3, 7, "t6a");
        sys_rst = 1'b1;
        baud_tick = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("t6_rst_txd", 16'(txd_s), 16'd1);
        chk("t6_rst_busy", 16'(busy_s), 16'd0);
        chk("t6_rst_ready", 16'(rdy_s), 16'd0);
        sys_rst = 1'b0;
        baud_tick = 1'b0;
        #1 chk("t6_ready", 16'(rdy_s), 16'd1);
        write_word(8'h3C);
        expect_bits({6'd0, 1'b1, 8'h3C, 1'b0}, 0, 10, "t6b");
        end_tick(1'b1, "t6b");
        chk("t6_busy_end", 16'(busy_s), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
